// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewing operand feeder for an NxN systolic array
//
// Buffers K load vectors (one element per north lane and per west lane),
// then streams them into the array edges with lane i delayed by i cycles.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   load_valid_i/_ready_o  load handshake, one vector pair per accepted beat
//   load_north_i[N]      north lane elements of the load vector
//   load_west_i[N]       west lane elements of the load vector
//   start_i              begin streaming a full buffer
//   abort_i              synchronous clear of buffer and stream
//   north_o[N], west_o[N]  skewed edge data (registered)
//   inputs_valid_o       lane 0 presents a stored element
//   last_element_o       lane N-1 presents its final element
//   full_o, busy_o       buffer full / stream in progress
//   done_o               one-cycle pulse after a completed stream

module systolic_feeder #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 32,
  parameter int K          = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [DATA_WIDTH-1:0] load_north_i [0:N-1],
  input  logic [DATA_WIDTH-1:0] load_west_i  [0:N-1],
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [DATA_WIDTH-1:0] north_o      [0:N-1],
  output logic [DATA_WIDTH-1:0] west_o       [0:N-1],
  output logic                  inputs_valid_o,
  output logic                  last_element_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int WPW = $clog2(K + 1);
  localparam int CW  = $clog2(K + N);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_FULL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [CW-1:0]  LAST_CNT  = CW'(K + N - 2);
  localparam logic [WPW-1:0] LAST_WPTR = WPW'(K - 1);

  logic [1:0]            r_state;
  logic [WPW-1:0]        r_wptr;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_nstore [0:K-1][0:N-1];
  logic [DATA_WIDTH-1:0] r_wstore [0:K-1][0:N-1];
  logic [DATA_WIDTH-1:0] r_north  [0:N-1];
  logic [DATA_WIDTH-1:0] r_west   [0:N-1];
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;

  logic [1:0]            w_ns;
  logic [WPW-1:0]        w_nwptr;
  logic [CW-1:0]         w_ncnt;
  logic                  w_write;
  logic                  w_done_n;
  logic [DATA_WIDTH-1:0] w_north_n [0:N-1];
  logic [DATA_WIDTH-1:0] w_west_n  [0:N-1];
  logic                  w_valid_n;
  logic                  w_last_n;

  always_comb begin
    w_ns     = r_state;
    w_nwptr  = r_wptr;
    w_ncnt   = r_cnt;
    w_write  = 1'b0;
    w_done_n = 1'b0;
    if (abort_i) begin
      w_ns    = ST_LOAD;
      w_nwptr = '0;
      w_ncnt  = '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (load_valid_i) begin
            w_write = 1'b1;
            w_nwptr = r_wptr + 1'b1;
            if (r_wptr == LAST_WPTR) w_ns = ST_FULL;
          end
        end
        ST_FULL: begin
          if (start_i) begin
            w_ns   = ST_STREAM;
            w_ncnt = '0;
          end
        end
        ST_STREAM: begin
          if (r_cnt == LAST_CNT) begin
            w_ns     = ST_LOAD;
            w_ncnt   = '0;
            w_nwptr  = '0;
            w_done_n = 1'b1;
          end else begin
            w_ncnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_ns    = ST_LOAD;
          w_nwptr = '0;
          w_ncnt  = '0;
        end
      endcase
    end
  end

  // Outputs are precomputed from the next-cycle count so they leave registers
  // aligned with the count: lane i shows entry t-i, i.e. t == i + e.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_north_n[i] = '0;
      w_west_n[i]  = '0;
      for (int e = 0; e < K; e++) begin
        if (w_ns == ST_STREAM && w_ncnt == CW'(i + e)) begin
          w_north_n[i] = r_nstore[e][i];
          w_west_n[i]  = r_wstore[e][i];
        end
      end
    end
    w_valid_n = (w_ns == ST_STREAM) && (w_ncnt < CW'(K));
    w_last_n  = (w_ns == ST_STREAM) && (w_ncnt == LAST_CNT);
  end

  // Buffer contents need no reset; only written entries are ever streamed.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      for (int e = 0; e < K; e++) begin
        if (r_wptr == WPW'(e)) begin
          for (int i = 0; i < N; i++) begin
            r_nstore[e][i] <= load_north_i[i];
            r_wstore[e][i] <= load_west_i[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_LOAD;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_north[i] <= '0;
        r_west[i]  <= '0;
      end
    end else begin
      r_state <= w_ns;
      r_wptr  <= w_nwptr;
      r_cnt   <= w_ncnt;
      r_valid <= w_valid_n;
      r_last  <= w_last_n;
      r_done  <= w_done_n;
      for (int i = 0; i < N; i++) begin
        r_north[i] <= w_north_n[i];
        r_west[i]  <= w_west_n[i];
      end
    end
  end

  assign north_o        = r_north;
  assign west_o         = r_west;
  assign inputs_valid_o = r_valid;
  assign last_element_o = r_last;
  assign done_o         = r_done;
  assign load_ready_o   = (r_state == ST_LOAD);
  assign full_o         = (r_state == ST_FULL);
  assign busy_o         = (r_state == ST_STREAM);

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed table-driven bench for systolic_feeder (N=2, K=2)

module tb_systolic_feeder;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] load_north_i [0:1];
  logic [31:0] load_west_i  [0:1];
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] north_o [0:1];
  logic [31:0] west_o  [0:1];
  logic        inputs_valid_o;
  logic        last_element_o;
  logic        full_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  systolic_feeder #(.N(2), .DATA_WIDTH(32), .K(2)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .load_valid_i   (load_valid_i),
    .load_ready_o   (load_ready_o),
    .load_north_i   (load_north_i),
    .load_west_i    (load_west_i),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .north_o        (north_o),
    .west_o         (west_o),
    .inputs_valid_o (inputs_valid_o),
    .last_element_o (last_element_o),
    .full_o         (full_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  typedef struct {
    logic        lv;
    logic [31:0] n0, n1, w0, w1;
    logic        st, ab;
    logic [31:0] en0, en1, ew0, ew1;
    logic        ev, el, ef, eb, ed, er;
  } row_t;

  row_t rows [0:23];

  function automatic row_t mk(logic lv, logic [31:0] n0, logic [31:0] n1,
                              logic [31:0] w0, logic [31:0] w1, logic st, logic ab,
                              logic [31:0] en0, logic [31:0] en1,
                              logic [31:0] ew0, logic [31:0] ew1,
                              logic ev, logic el, logic ef, logic eb, logic ed, logic er);
    row_t r;
    r.lv = lv; r.n0 = n0; r.n1 = n1; r.w0 = w0; r.w1 = w1; r.st = st; r.ab = ab;
    r.en0 = en0; r.en1 = en1; r.ew0 = ew0; r.ew1 = ew1;
    r.ev = ev; r.el = el; r.ef = ef; r.eb = eb; r.ed = ed; r.er = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input row_t r);
    chk({tag, " north0"}, north_o[0], r.en0);
    chk({tag, " north1"}, north_o[1], r.en1);
    chk({tag, " west0"},  west_o[0],  r.ew0);
    chk({tag, " west1"},  west_o[1],  r.ew1);
    chk({tag, " valid"},  32'(inputs_valid_o), 32'(r.ev));
    chk({tag, " last"},   32'(last_element_o), 32'(r.el));
    chk({tag, " full"},   32'(full_o),         32'(r.ef));
    chk({tag, " busy"},   32'(busy_o),         32'(r.eb));
    chk({tag, " done"},   32'(done_o),         32'(r.ed));
    chk({tag, " ready"},  32'(load_ready_o),   32'(r.er));
  endtask

  // Inputs of a row are driven for one cycle; its expectations are the
  // outputs seen in the following cycle.
  task automatic apply(input string tag, input row_t r);
    load_valid_i    = r.lv;
    load_north_i[0] = r.n0;
    load_north_i[1] = r.n1;
    load_west_i[0]  = r.w0;
    load_west_i[1]  = r.w1;
    start_i         = r.st;
    abort_i         = r.ab;
    @(negedge clk_i);
    chk_all(tag, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t idle;
    row_t z;
    //            lv n0 n1 w0 w1 st ab  en0 en1 ew0 ew1 ev el ef eb ed er
    rows[0]  = mk(1, 1, 2, 5, 6, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    rows[1]  = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // early start ignored
    rows[2]  = mk(1, 3, 4, 7, 8, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 0, 0); // K-th write -> full
    rows[3]  = mk(1, 9, 9, 9, 9, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 0, 0); // backpressure
    rows[4]  = mk(1, 9, 9, 9, 9, 1, 0,  1, 0, 5, 0,   1, 0, 0, 1, 0, 0); // S -> S+1
    rows[5]  = mk(1, 9, 9, 9, 9, 0, 0,  3, 2, 7, 6,   1, 0, 0, 1, 0, 0); // S+2
    rows[6]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 4, 0, 8,   0, 1, 0, 1, 0, 0); // S+3
    rows[7]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 1, 1); // S+4 done
    rows[8]  = mk(1, 11, 12, 15, 16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rows[9]  = mk(1, 13, 14, 17, 18, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rows[10] = mk(0, 0, 0, 0, 0, 1, 0,  11, 0, 15, 0,  1, 0, 0, 1, 0, 0);
    rows[11] = mk(0, 0, 0, 0, 0, 1, 0,  13, 12, 17, 16, 1, 0, 0, 1, 0, 0); // start in STREAM ignored
    rows[12] = mk(0, 0, 0, 0, 0, 0, 0,  0, 14, 0, 18,  0, 1, 0, 1, 0, 0);
    rows[13] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
    rows[14] = mk(0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // start in LOAD, empty
    rows[15] = mk(1, 21, 22, 25, 26, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rows[16] = mk(1, 23, 24, 27, 28, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    rows[17] = mk(0, 0, 0, 0, 0, 1, 0,  21, 0, 25, 0,  1, 0, 0, 1, 0, 0); // S+1
    rows[18] = mk(0, 0, 0, 0, 0, 0, 0,  23, 22, 27, 26, 1, 0, 0, 1, 0, 0); // S+2
    rows[19] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // abort -> S+3 clear
    rows[20] = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // no done pulse
    rows[21] = mk(1, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // wptr restarted at 0
    rows[22] = mk(1, 1, 1, 1, 1, 0, 0,  0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    rows[23] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // abort in FULL

    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    load_north_i[0] = '0; load_north_i[1] = '0;
    load_west_i[0]  = '0; load_west_i[1]  = '0;

    // Reset held for three cycles, checked one cycle after release.
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk_all("reset", z);

    for (int r = 0; r < 24; r++) apply($sformatf("row%0d", r), rows[r]);

    // Reset asserted mid-stream terminates at once and leaves no pulses.
    apply("mr_load0", mk(1, 31, 32, 35, 36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    apply("mr_load1", mk(1, 33, 34, 37, 38, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    apply("mr_start", mk(0, 0, 0, 0, 0, 1, 0, 31, 0, 35, 0, 1, 0, 0, 1, 0, 0));
    start_i = 1'b0;
    rstn_i  = 1'b0;
    #1;
    chk_all("mr_async", z);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle = z;
    for (int c = 0; c < 4; c++) apply($sformatf("mr_after%0d", c), idle);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
